// File: rtl/nested_struct_pipe_if.sv
// Valid/ready stream carrying one flattened nested record
// together with its per-record mode bit.
interface nested_struct_pipe_if #(
   parameter int REC_W = 62
);
   logic             valid;
   logic             ready;
   logic             mode;
   logic [REC_W-1:0] data;

   modport master (
      output valid,
      output mode,
      output data,
      input  ready
   );

   modport slave (
      input  valid,
      input  mode,
      input  data,
      output ready
   );
endinterface

// File: rtl/nested_struct_pipe.sv
// Two-stage handshaked pipeline applying a field transform or bypass
// to a nested packed record; counts deliveries, flags address wrap.
module nested_struct_pipe #(
   parameter int unsigned           ADDR_W   = 8,
   parameter int unsigned           DATA_W   = 32,
   parameter int unsigned           ID_W     = 16,
   parameter int unsigned           CMD_W    = 4,
   parameter int unsigned           ADDR_INC = 1,
   parameter logic [DATA_W-1:0]     DATA_KEY = 32'hDEADBEEF,
   parameter int unsigned           ID_INC   = 100,
   parameter logic [CMD_W-1:0]      CMD_MASK = 4'b1010,
   parameter int unsigned           CNT_W    = 16,
   localparam int unsigned          REC_W    =
      1 + CMD_W + ID_W + ADDR_W + DATA_W + 1
) (
   input  logic                  clk,
   input  logic                  rst,
   nested_struct_pipe_if.slave   in_s,
   nested_struct_pipe_if.master  out_m,
   output logic [CNT_W-1:0]      rec_count_o,
   output logic                  addr_wrap_o
);

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic              valid;
   } base_t;

   typedef struct packed {
      logic             ready;
      logic [CMD_W-1:0] cmd;
      logic [ID_W-1:0]  id;
      base_t            base;
   } rec_t;

   logic             s1_valid_q;
   logic             s1_mode_q;
   rec_t             s1_rec_q;
   logic             s2_valid_q;
   logic             s2_mode_q;
   rec_t             s2_rec_q;
   logic [CNT_W-1:0] cnt_q;
   logic             wrap_q;

   logic             s1_adv;
   logic             s2_adv;
   logic             in_fire;
   logic             out_fire;
   rec_t             x_rec_d;
   logic             x_wrap_d;
   logic [ADDR_W:0]  addr_sum;

   assign s2_adv   = !s2_valid_q || out_m.ready;
   assign s1_adv   = !s1_valid_q || s2_adv;
   assign in_fire  = in_s.valid && s1_adv && !rst;
   assign out_fire = s2_valid_q && out_m.ready;

   assign in_s.ready  = s1_adv && !rst;
   assign out_m.valid = s2_valid_q;
   assign out_m.data  = s2_rec_q;
   assign out_m.mode  = s2_mode_q;
   assign rec_count_o = cnt_q;
   assign addr_wrap_o = wrap_q;

   // Every transformed field derives from the original S1 record.
   always_comb begin
      x_rec_d  = s1_rec_q;
      x_wrap_d = 1'b0;
      addr_sum = {1'b0, s1_rec_q.base.addr} + (ADDR_W+1)'(ADDR_INC);
      if (s1_mode_q) begin
         x_rec_d.base.addr  = addr_sum[ADDR_W-1:0];
         x_rec_d.base.data  = s1_rec_q.base.data ^ DATA_KEY;
         x_rec_d.base.valid = s1_rec_q.base.valid & s1_rec_q.ready;
         x_rec_d.id         = s1_rec_q.id + ID_W'(ID_INC);
         x_rec_d.cmd        = s1_rec_q.cmd | CMD_MASK;
         x_rec_d.ready      = s1_rec_q.base.valid;
         x_wrap_d           = addr_sum[ADDR_W];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_mode_q  <= 1'b0;
         s1_rec_q   <= '0;
         s2_valid_q <= 1'b0;
         s2_mode_q  <= 1'b0;
         s2_rec_q   <= '0;
         cnt_q      <= '0;
         wrap_q     <= 1'b0;
      end else begin
         if (s1_adv) begin
            s1_valid_q <= in_fire;
            if (in_fire) begin
               s1_rec_q  <= in_s.data;
               s1_mode_q <= in_s.mode;
            end
         end
         if (s2_adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
               s2_rec_q  <= x_rec_d;
               s2_mode_q <= s1_mode_q;
               if (x_wrap_d) wrap_q <= 1'b1;
            end
         end
         if (out_fire) cnt_q <= cnt_q + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_nested_struct_pipe.sv
// Directed checks of nested_struct_pipe: transform, bypass, wrap flag,
// backpressure streaming, mid-flight reset and counter wrap.
module tb_nested_struct_pipe;
   localparam int REC_W = 62;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rst2 = 1'b1;
   logic [15:0] cnt;
   logic [3:0]  cnt2;
   logic        wrap;
   logic        wrap2;

   int n_tests = 0;
   int n_fail  = 0;

   nested_struct_pipe_if #(.REC_W(REC_W)) iif  ();
   nested_struct_pipe_if #(.REC_W(REC_W)) oif  ();
   nested_struct_pipe_if #(.REC_W(REC_W)) iif2 ();
   nested_struct_pipe_if #(.REC_W(REC_W)) oif2 ();

   nested_struct_pipe dut (
      .clk         (clk),
      .rst         (rst),
      .in_s        (iif.slave),
      .out_m       (oif.master),
      .rec_count_o (cnt),
      .addr_wrap_o (wrap)
   );

   nested_struct_pipe #(.CNT_W(4)) dut4 (
      .clk         (clk),
      .rst         (rst2),
      .in_s        (iif2.slave),
      .out_m       (oif2.master),
      .rec_count_o (cnt2),
      .addr_wrap_o (wrap2)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [61:0] mk(logic rdy, logic [3:0] cmd,
      logic [15:0] id, logic [7:0] addr, logic [31:0] data, logic v);
      return {rdy, cmd, id, addr, data, v};
   endfunction

   function automatic logic [61:0] xf(logic [61:0] r, logic m);
      if (!m) return r;
      return {r[0], r[60:57] | 4'hA, r[56:41] + 16'd100,
              r[40:33] + 8'd1, r[32:1] ^ 32'hDEADBEEF, r[0] & r[61]};
   endfunction

   logic [61:0] vec [8];
   logic        vmode [8];
   logic [61:0] held;
   logic        stalled;
   logic        saw_low;
   int          sent;
   int          got;

   initial begin
      iif.valid = 0; iif.mode = 0; iif.data = '0; oif.ready = 1;
      iif2.valid = 0; iif2.mode = 0; iif2.data = '0; oif2.ready = 1;
      tick(); tick();
      chk("rst_in_ready", iif.ready, 0);
      rst = 0;
      tick();
      chk("rst_out_valid", oif.valid, 0);
      chk("rst_out_data", oif.data, 0);
      chk("rst_count", cnt, 0);
      chk("rst_wrap", wrap, 0);
      chk("rst_in_ready_rel", iif.ready, 1);

      // transform
      iif.valid = 1; iif.mode = 1;
      iif.data = mk(1, 4'h1, 16'h0010, 8'h05, 32'h0, 1);
      tick();
      iif.valid = 0;
      chk("t1_lat1", oif.valid, 0);
      tick();
      chk("t1_valid", oif.valid, 1);
      chk("t1_data", oif.data,
          mk(1, 4'hB, 16'h0074, 8'h06, 32'hDEADBEEF, 1));
      tick();
      chk("t1_count", cnt, 1);
      chk("t1_drained", oif.valid, 0);

      // bypass
      iif.valid = 1; iif.mode = 0;
      tick();
      iif.valid = 0;
      tick();
      chk("t2_data", oif.data, mk(1, 4'h1, 16'h0010, 8'h05, 32'h0, 1));
      chk("t2_wrap", wrap, 0);
      tick();
      chk("t2_count", cnt, 2);

      // address and id wrap
      iif.valid = 1; iif.mode = 1;
      iif.data = mk(1, 4'h1, 16'hFFFF, 8'hFF, 32'h0, 1);
      tick();
      iif.valid = 0;
      tick();
      chk("t3_data", oif.data,
          mk(1, 4'hB, 16'h0063, 8'h00, 32'hDEADBEEF, 1));
      chk("t3_wrap", wrap, 1);
      iif.valid = 1; iif.mode = 0;
      iif.data = mk(0, 4'h2, 16'h1234, 8'h10, 32'h55, 0);
      tick();
      iif.valid = 0;
      tick(); tick();
      chk("t3_wrap_sticky", wrap, 1);
      chk("t3_count", cnt, 4);

      // stream with backpressure
      rst = 1;
      tick();
      rst = 0;
      chk("t4_wrap_clr", wrap, 0);
      for (int i = 0; i < 8; i++) begin
         vec[i] = mk(i[0], i[3:0], 16'(i * 16'h1111), 8'(8'hF0 + i * 3),
                     32'h1234_5678 * (i + 1), i[1]);
         vmode[i] = (i % 3) != 0;
      end
      sent = 0; got = 0; stalled = 0; saw_low = 0; held = '0;
      for (int c = 0; c < 40 && got < 8; c++) begin
         oif.ready = !(c >= 3 && c <= 5);
         iif.valid = sent < 8;
         iif.data  = vec[sent < 8 ? sent : 7];
         iif.mode  = vmode[sent < 8 ? sent : 7];
         #1;
         if (stalled) chk("t4_stable", oif.data, held);
         stalled = 0;
         if (!iif.ready) saw_low = 1;
         if (iif.valid && iif.ready) sent++;
         if (oif.valid && oif.ready) begin
            chk($sformatf("t4_rec%0d", got), oif.data,
                xf(vec[got], vmode[got]));
            got++;
         end else if (oif.valid) begin
            stalled = 1;
            held = oif.data;
         end
         tick();
      end
      iif.valid = 0; oif.ready = 1;
      tick();
      chk("t4_all_arrived", got, 8);
      chk("t4_in_ready_low", saw_low, 1);
      chk("t4_count", cnt, 8);

      // reset with both stages full
      oif.ready = 0; iif.valid = 1; iif.mode = 1;
      iif.data = mk(1, 4'h0, 16'h0, 8'hFF, 32'h1, 1);
      tick();
      iif.data = mk(0, 4'h3, 16'h7, 8'h01, 32'h2, 0);
      tick();
      iif.valid = 0;
      chk("t5_full_valid", oif.valid, 1);
      chk("t5_full_in_ready", iif.ready, 0);
      chk("t5_wrap_set", wrap, 1);
      rst = 1;
      chk("t5_rst_in_ready", iif.ready, 0);
      tick();
      rst = 0; oif.ready = 1;
      chk("t5_out_valid", oif.valid, 0);
      chk("t5_out_data", oif.data, 0);
      chk("t5_count", cnt, 0);
      chk("t5_wrap", wrap, 0);
      tick();
      chk("t5_no_leftover", oif.valid, 0);
      iif.valid = 1; iif.mode = 0;
      iif.data = mk(1, 4'h5, 16'hABCD, 8'h33, 32'hCAFEF00D, 0);
      tick();
      iif.valid = 0;
      chk("t5_lat1", oif.valid, 0);
      tick();
      chk("t5_lat2", oif.valid, 1);
      chk("t5_data", oif.data,
          mk(1, 4'h5, 16'hABCD, 8'h33, 32'hCAFEF00D, 0));

      // 4-bit counter wrap
      rst2 = 0;
      iif2.valid = 1; iif2.mode = 1;
      iif2.data = mk(1, 4'h1, 16'h2, 8'h3, 32'h4, 1);
      for (int k = 0; k < 17; k++) tick();
      iif2.valid = 0;
      tick(); tick(); tick();
      chk("t6_count_wrap", cnt2, 1);
      chk("t6_idle", oif2.valid, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
